// File: rtl/inst_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_enc_pkg
//  Description : Shared definitions for the instruction encoder: format codes,
//                RV32I base opcodes, the decoded-field bundle and a helper
//                for signed immediate range tests.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_enc_pkg;

    // Instruction format codes carried on in_fmt. Codes 6 and 7 are invalid.
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // RV32I base opcodes.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Decoded fields presented to the packer.
    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } inst_fields_t;

    // True when 'value' is representable as a 'width'-bit two's complement
    // number, i.e. every bit from width-1 upward equals the sign bit.
    function automatic logic fits_signed(input logic [31:0] value,
                                         input int unsigned width);
        logic [31:0] upper;
        upper = 32'($signed(value) >>> (width - 1));
        return (upper == '0) || (upper == '1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder_if
//  Description : Handshake bundle of the instruction encoder.
//                Input side : in_valid/in_ready plus decoded fields
//                             (in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
//                              in_funct3, in_funct7, in_imm).
//                Output side: out_valid/out_ready, out_inst, out_addr.
//                slave  = encoder view, master = producer/consumer view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_encoder_if #(
    parameter int ADDR_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr
    );

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr
    );
endinterface
`default_nettype wire

// File: rtl/inst_encoder_pack.sv
`default_nettype none
// ============================================================================
//  Module      : inst_pack
//  Description : Combinational field packer. Scatters the immediate per
//                format (inverse of an immediate generator) and flags inputs
//                that must be rejected.
//  Ports       : i_fields  decoded fields (inst_fields_t)
//                o_inst    packed 32-bit instruction word
//                o_reject  input must not produce a word
//  Build option: INST_ENC_RANGE_CHECK_EN - when defined, immediates that do
//                not fit their format are rejected; otherwise excess bits
//                are silently dropped and only format codes 6/7 reject.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_pack
    import inst_enc_pkg::*;
(
    input  inst_fields_t i_fields,
    output logic [31:0]  o_inst,
    output logic         o_reject
);

    logic [31:0] w_imm;
    logic        w_fmt_bad;
    logic        w_range_bad;

    assign w_imm = i_fields.imm;

    always_comb begin
        o_inst    = '0;
        w_fmt_bad = 1'b0;
        case (i_fields.fmt)
            FMT_R: o_inst = {i_fields.funct7, i_fields.rs2, i_fields.rs1,
                             i_fields.funct3, i_fields.rd, i_fields.opcode};
            FMT_I: o_inst = {w_imm[11:0], i_fields.rs1,
                             i_fields.funct3, i_fields.rd, i_fields.opcode};
            FMT_S: o_inst = {w_imm[11:5], i_fields.rs2, i_fields.rs1,
                             i_fields.funct3, w_imm[4:0], i_fields.opcode};
            FMT_B: o_inst = {w_imm[12], w_imm[10:5], i_fields.rs2,
                             i_fields.rs1, i_fields.funct3, w_imm[4:1],
                             w_imm[11], i_fields.opcode};
            FMT_U: o_inst = {w_imm[31:12], i_fields.rd, i_fields.opcode};
            FMT_J: o_inst = {w_imm[20], w_imm[10:1], w_imm[11],
                             w_imm[19:12], i_fields.rd, i_fields.opcode};
            default: w_fmt_bad = 1'b1;
        endcase
    end

`ifdef INST_ENC_RANGE_CHECK_EN
    // Branch and jump offsets are byte offsets to halfword-aligned targets,
    // so bit 0 must be clear as well as the value fitting the field.
    always_comb begin
        w_range_bad = 1'b0;
        case (i_fields.fmt)
            FMT_I, FMT_S: w_range_bad = !fits_signed(w_imm, 12);
            FMT_B:        w_range_bad = !fits_signed(w_imm, 13) || w_imm[0];
            FMT_J:        w_range_bad = !fits_signed(w_imm, 21) || w_imm[0];
            FMT_U:        w_range_bad = (w_imm[11:0] != 12'd0);
            default:      w_range_bad = 1'b0;
        endcase
    end
`else
    assign w_range_bad = 1'b0;
`endif

    assign o_reject = w_fmt_bad | w_range_bad;

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder
//  Description : Packs decoded RISC-V fields into 32-bit instruction words and
//                streams them, each tagged with a sequential word address,
//                through a 2-entry output buffer (full throughput under
//                backpressure). Rejected inputs raise sticky error state.
//  Ports       : clk        rising-edge clock
//                reset      asynchronous active-low reset
//                restart    sync pulse: reload address, clear errors, drop
//                           buffered words
//                bus        inst_encoder_if.slave handshake bundle
//                err_range  sticky: an input was rejected
//                err_count  rejected-input count, saturates at 255
//  Build option: INST_ENC_RANGE_CHECK_EN (immediate range checking, see
//                inst_pack).
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       restart,
    inst_encoder_if.slave   bus,
    output logic            err_range,
    output logic [7:0]      err_count
);

    localparam logic [1:0] C_DEPTH = 2'd2;

    // Output buffer: two slots addressed by 1-bit read/write pointers.
    logic [31:0]       buf_inst_q [2];
    logic [31:0]       buf_inst_d [2];
    logic [ADDR_W-1:0] buf_addr_q [2];
    logic [ADDR_W-1:0] buf_addr_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              err_range_q, err_range_d;
    logic [7:0]        err_count_q, err_count_d;

    inst_fields_t      w_fields;
    logic [31:0]       w_inst;
    logic              w_reject;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    always_comb begin
        w_fields        = '0;
        w_fields.fmt    = bus.in_fmt;
        w_fields.opcode = bus.in_opcode;
        w_fields.rd     = bus.in_rd;
        w_fields.rs1    = bus.in_rs1;
        w_fields.rs2    = bus.in_rs2;
        w_fields.funct3 = bus.in_funct3;
        w_fields.funct7 = bus.in_funct7;
        w_fields.imm    = bus.in_imm;
    end

    inst_pack u_pack (
        .i_fields (w_fields),
        .o_inst   (w_inst),
        .o_reject (w_reject)
    );

    // A rejected input still completes its handshake; it simply writes
    // nothing into the buffer and does not consume an address.
    assign w_accept = bus.in_valid & in_ready_q;
    assign w_push   = w_accept & ~w_reject;
    assign w_pop    = (count_q != 2'd0) & bus.out_ready;

    always_comb begin
        buf_inst_d  = buf_inst_q;
        buf_addr_d  = buf_addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        next_addr_d = next_addr_q;
        err_range_d = err_range_q;
        err_count_d = err_count_q;

        if (restart) begin
            // Restart wins over any handshake in the same cycle.
            for (int i = 0; i < 2; i++) begin
                buf_inst_d[i] = '0;
                buf_addr_d[i] = BASE_ADDR;
            end
            rd_ptr_d    = 1'b0;
            wr_ptr_d    = 1'b0;
            count_d     = 2'd0;
            next_addr_d = BASE_ADDR;
            err_range_d = 1'b0;
            err_count_d = 8'd0;
        end else begin
            if (w_push) begin
                buf_inst_d[wr_ptr_q] = w_inst;
                buf_addr_d[wr_ptr_q] = next_addr_q;
                wr_ptr_d             = ~wr_ptr_q;
                next_addr_d          = next_addr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (w_accept && w_reject) begin
                err_range_d = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
        end

        // Registered ready: depends on the next occupancy, so out_ready
        // never reaches in_ready within the same cycle.
        in_ready_d = (count_d != C_DEPTH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                buf_inst_q[i] <= '0;
                buf_addr_q[i] <= BASE_ADDR;
            end
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            next_addr_q <= BASE_ADDR;
            err_range_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            buf_inst_q  <= buf_inst_d;
            buf_addr_q  <= buf_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            next_addr_q <= next_addr_d;
            err_range_q <= err_range_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_inst  = buf_inst_q[rd_ptr_q];
    assign bus.out_addr  = buf_addr_q[rd_ptr_q];
    assign err_range     = err_range_q;
    assign err_count     = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_encoder
//  Description : Self-checking bench for inst_encoder with a queue-based
//                reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;
    import inst_enc_pkg::*;

    localparam int          ADDR_W = 32;
    // Base just below the top of the address space so the wrap is exercised.
    localparam logic [31:0] BASE   = 32'hFFFF_FFFE;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       restart = 1'b0;
    logic       err_range;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [31:0] exp_inst [$];
    logic [31:0] exp_addr [$];
    logic [31:0] m_addr;
    logic        m_err_range;
    int          m_err_count;

    inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .bus       (bus),
        .err_range (err_range),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] field(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] model_encode(input logic [2:0] fmt, input logic [6:0] op,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        logic [31:0] w;
        w = 32'(op);
        case (fmt)
            3'd0: w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20) | (32'(f7) << 25);
            3'd1: w = w | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (field(imm, 11, 0) << 20);
            3'd2: w = w | (field(imm, 4, 0) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                        | (field(imm, 11, 5) << 25);
            3'd3: w = w | (field(imm, 11, 11) << 7) | (field(imm, 4, 1) << 8) | (32'(f3) << 12)
                        | (32'(rs1) << 15) | (32'(rs2) << 20) | (field(imm, 10, 5) << 25)
                        | (field(imm, 12, 12) << 31);
            3'd4: w = w | (32'(rd) << 7) | (field(imm, 31, 12) << 12);
            3'd5: w = w | (32'(rd) << 7) | (field(imm, 19, 12) << 12) | (field(imm, 11, 11) << 20)
                        | (field(imm, 10, 1) << 21) | (field(imm, 20, 20) << 31);
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic bit model_reject(input logic [2:0] fmt, input logic [31:0] imm);
        longint s;
        s = longint'($signed(imm));
        if (fmt > 3'd5) return 1'b1;
`ifdef INST_ENC_RANGE_CHECK_EN
        case (fmt)
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3:       return (s < -4096) || (s > 4094) || (s % 2 != 0);
            3'd5:       return (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 2) || (s % 2 != 0);
            3'd4:       return (imm % 4096) != 0;
            default:    return 1'b0;
        endcase
`else
        return (s != s) ? 1'b1 : 1'b0;
`endif
    endfunction

    task automatic model_clear();
        exp_inst.delete();
        exp_addr.delete();
        m_addr      = BASE;
        m_err_range = 1'b0;
        m_err_count = 0;
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] imm);
        bus.in_fmt    = fmt;
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask

    // Called at a falling edge with inputs set: checks the visible state,
    // advances the model by one clock and returns at the next falling edge.
    task automatic step();
        int occ;
        occ = exp_inst.size();
        checks++;
        if (bus.out_valid !== (occ != 0)) begin
            failures++;
            $display("FAIL out_valid got=%0b exp=%0b", bus.out_valid, occ != 0);
        end
        checks++;
        if (bus.in_ready !== (occ < 2)) begin
            failures++;
            $display("FAIL in_ready got=%0b exp=%0b", bus.in_ready, occ < 2);
        end
        checks++;
        if (err_range !== m_err_range || err_count !== 8'(m_err_count)) begin
            failures++;
            $display("FAIL errors got=%0b/%0d exp=%0b/%0d", err_range, err_count, m_err_range, m_err_count);
        end
        if (occ > 0) begin
            checks++;
            if (bus.out_inst !== exp_inst[0] || bus.out_addr !== exp_addr[0]) begin
                failures++;
                $display("FAIL head got=%h@%h exp=%h@%h", bus.out_inst, bus.out_addr, exp_inst[0], exp_addr[0]);
            end
        end
        if (restart) begin
            model_clear();
        end else begin
            if (occ > 0 && bus.out_ready) begin
                void'(exp_inst.pop_front());
                void'(exp_addr.pop_front());
            end
            if (bus.in_valid && occ < 2) begin
                if (model_reject(bus.in_fmt, bus.in_imm)) begin
                    m_err_range = 1'b1;
                    if (m_err_count < 255) m_err_count++;
                end else begin
                    exp_inst.push_back(model_encode(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1,
                        bus.in_rs2, bus.in_funct3, bus.in_funct7, bus.in_imm));
                    exp_addr.push_back(m_addr);
                    m_addr = m_addr + 32'd1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_word(input string name, input logic [31:0] lit);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_inst !== lit) begin
            failures++;
            $display("FAIL %s got=%h valid=%0b exp=%h", name, bus.out_inst, bus.out_valid, lit);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_inst !== 32'd0 ||
            bus.out_addr !== BASE || err_range !== 1'b0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_state got v=%0b r=%0b i=%h a=%h e=%0b/%0d exp v=0 r=1 i=0 a=%h e=0/0",
                bus.out_valid, bus.in_ready, bus.out_inst, bus.out_addr, err_range, err_count, BASE);
        end
    endtask

    task automatic test_directed();
        bus.out_ready = 1'b1;
        drive(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
        expect_word("addi", 32'h0050_0093);
        checks++;
        if (bus.out_addr !== BASE) begin
            failures++;
            $display("FAIL addi_addr got=%h exp=%h", bus.out_addr, BASE);
        end
        step();
        drive(FMT_S, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
        expect_word("sw", 32'h0020_A423); step();
        drive(FMT_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
        bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
        expect_word("beq", 32'hFE00_0EE3); step();
        drive(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
        expect_word("jal", 32'h0080_00EF); step();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(FMT_R, OPC_OP, 5'(i + 3), 5'(i), 5'(i + 7), 3'(i), 7'h20, 32'd0);
            step();
        end
        bus.in_valid = 1'b0;
        step(); step();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(FMT_U, OPC_LUI, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1) << 12);
            step();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready got=%0b exp=0", bus.in_ready);
        end
        step(); step();
        bus.out_ready = 1'b1;
        step(); step(); step();
    endtask

    task automatic test_range_error();
        bus.out_ready = 1'b1;
        drive(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
`ifdef INST_ENC_RANGE_CHECK_EN
        checks++;
        if (bus.out_valid !== 1'b0 || err_range !== 1'b1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL range_reject got v=%0b e=%0b/%0d exp v=0 e=1/1", bus.out_valid, err_range, err_count);
        end
`else
        expect_word("range_trunc", 32'h8000_0093);
`endif
        step();
        drive(FMT_I, OPC_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
        step();
        // Invalid format code is rejected in every build.
        drive(3'd6, OPC_OP, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_restart();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(FMT_I, OPC_LOAD, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'd16); step();
        drive(FMT_I, OPC_LOAD, 5'd6, 5'd5, 5'd0, 3'd2, 7'd0, 32'd20); step();
        bus.in_valid = 1'b0;
        restart = 1'b1; step(); restart = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_addr !== BASE || err_range !== 1'b0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL restart got v=%0b a=%h e=%0b/%0d exp v=0 a=%h e=0/0",
                bus.out_valid, bus.out_addr, err_range, err_count, BASE);
        end
        bus.out_ready = 1'b1;
        drive(FMT_J, OPC_JAL, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
        bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive(FMT_S, OPC_STORE, 5'd0, 5'd3, 5'd9, 3'd1, 7'd0, 32'd100); step();
        drive(FMT_S, OPC_STORE, 5'd0, 5'd3, 5'd9, 3'd1, 7'd0, 32'd104); step();
        bus.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_addr !== BASE) begin
            failures++;
            $display("FAIL async_reset got v=%0b r=%0b a=%h exp v=0 r=1 a=%h",
                bus.out_valid, bus.in_ready, bus.out_addr, BASE);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        drive(FMT_U, OPC_AUIPC, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
        bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive(3'd7, OPC_OP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        for (int i = 0; i < 260; i++) step();
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (err_count !== 8'd255 || err_range !== 1'b1) begin
            failures++;
            $display("FAIL saturation got=%0d/%0b exp=255/1", err_count, err_range);
        end
        restart = 1'b1; step(); restart = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm(input logic [2:0] fmt);
        int r;
        logic [31:0] v;
        logic [31:0] edges [12];
        edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095,
                  -32'sd4096, -32'sd4098, 32'd1048574, -32'sd1048576, 32'd1048576, 32'h12345000};
        r = $urandom_range(0, 9);
        if (r < 6) begin
            v = 32'($urandom_range(0, 8191)) - 32'd4096;
            if (fmt == FMT_B || fmt == FMT_J) v[0] = 1'b0;
            if (fmt == FMT_J) v = v << 6;
            if (fmt == FMT_U) v = $urandom() & 32'hFFFF_F000;
        end else if (r < 8) begin
            v = $urandom();
        end else begin
            v = edges[$urandom_range(0, 11)];
        end
        return v;
    endfunction

    task automatic test_random();
        logic [2:0] fmt;
        for (int i = 0; i < 400; i++) begin
            fmt = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            drive(fmt, 7'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
                  3'($urandom()), 7'($urandom()), rand_imm(fmt));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            restart       = ($urandom_range(0, 59) == 0);
            step();
        end
        restart       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step(); step(); step();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        model_clear();
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_range_error();
        test_restart();
        test_async_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Encodes instructions: takes decoded RISC-V fields plus a full 32-bit signed immediate and packs them into a 32-bit instruction word.
- Scatters immediate bits per format (I/S/B/U/J), the inverse of the immediate generator.
- Streams encoded words, tagged with a sequential word address, to the instruction-memory loader and bench program builders.
- Valid/ready handshake on both sides; 2-entry output buffer gives full throughput under backpressure.

Parameters:
ADDR_W, 32, width of out_addr word address
BASE_ADDR, 0, address loaded on reset and on restart

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
restart  in  1  sync pulse: reload address, clear errors, drop buffer
in_valid  in  1  input fields valid
in_ready  out  1  encoder can accept
in_fmt  in  3  format code (package constants)
in_opcode  in  7  opcode field
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R only)
in_imm  in  32  signed immediate (U: upper value with low 12 bits zero)
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts
out_inst  out  32  encoded instruction
out_addr  out  ADDR_W  word address of out_inst
err_range  out  1  sticky: an input was rejected
err_count  out  8  count of rejected inputs, saturates at 255

Behaviour:
- Reset values: out_valid=0, out_inst=0, out_addr=BASE_ADDR, err_range=0, err_count=0, buffer empty, in_ready=1.
- Accept when in_valid & in_ready; in_ready = buffer occupancy < 2 (registered, no combinational path from out_ready).
- Latency: accepted word appears at out_valid the next cycle when buffer is empty.
- Field packing:
  - R: funct7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Buffer: 2-entry FIFO. Head drives out_inst/out_addr; head is stable while out_valid & !out_ready.
- Address: counter assigned to each word at accept, +1 per accepted valid word, wraps modulo 2^ADDR_W.
- Simultaneous push and pop with buffer full: not possible (in_ready=0). With 1 entry: occupancy stays 1.
- Rejected input (see feature, or fmt 6/7):
  - Consumes the handshake; no word is buffered; the address does not advance.
  - err_range set; err_count incremented.
- restart: takes effect next edge and has priority over the handshake in that cycle.
  - Empties buffer; out_valid=0; address=BASE_ADDR; err_range and err_count cleared.
- Reset mid-transfer: everything discarded asynchronously.

Optional Feature:
INST_ENC_RANGE_CHECK_EN.
- Defined: reject immediates outside the format's range:
  - I/S: outside [-2048,2047].
  - B: outside [-4096,4094] or odd.
  - J: outside [-2^20,2^20-2] or odd.
  - U: imm[11:0]!=0.
- Undefined: no checking; out-of-range bits are silently truncated. Only fmt 6/7 are rejected.

Decomposition:
- Package inst_enc_pkg:
  - FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5.
  - Opcode constants matching the existing opcode definitions.
- Sub-module inst_pack: combinational field packer plus range checker. The top holds the FIFO, address counter and error counters.

Test Plan:
- I addi: op 0010011, rd 1, rs1 0, f3 0, imm 5 -> out_inst 0x00500093 at out_addr 0, one cycle after accept.
- S sw: op 0100011, rs1 1, rs2 2, f3 2, imm 8 -> 0x0020A423. B beq: op 1100011, x0,x0, imm -4 -> 0xFE000EE3.
- J jal: op 1101111, rd 1, imm 8 -> 0x008000EF. Back-to-back with out_ready=1: addresses 0,1,2, one word per cycle.
- Backpressure: out_ready=0, push 3 words -> first two accepted, in_ready=0, out_inst held. Release -> drains in order, addresses contiguous.
- Range error (macro defined): I imm 2048 -> no output, err_range=1, err_count=1. Next valid word gets the unadvanced address. Same stimulus without macro -> word 0x80000093 emitted.
- restart with 2 buffered words, and async reset mid-stream -> out_valid=0 next edge, addr=BASE_ADDR, errors 0.
